// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants for the nibble-serial adder: controller state encoding and
// the nibble width handled per clock by the datapath adder.
package nibble_serial_adder_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/FourBitFullAdder.sv
// Combinational 4-bit adder with carry-in/carry-out; the per-nibble datapath
// element driven by nibble_serial_adder.
module FourBitFullAdder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] Sum,
  output logic       Cout
);

  logic [4:0] c;

  assign c[0] = Cin;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign Sum[i]   = A[i] ^ B[i] ^ c[i];
    assign c[i + 1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end

  assign Cout = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-word adder that processes one nibble per clock, LS nibble first,
// with a registered inter-nibble carry and valid/ready on both sides.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIBBLES = WIDTH / NIB_W;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  if ((WIDTH < NIB_W) || ((WIDTH % NIB_W) != 0)) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             msb_a_q, msb_a_d;
  logic             msb_b_q, msb_b_d;

  logic             accept;
  logic             last_nib;
  logic [NIB_W-1:0] fa_sum;
  logic             fa_cout;

  assign accept   = in_valid && in_ready;
  assign last_nib = (cnt_q == CNT_W'(NIBBLES - 1));

  FourBitFullAdder u_fa (
    .A    (a_sh_q[NIB_W-1:0]),
    .B    (b_sh_q[NIB_W-1:0]),
    .Cin  (carry_q),
    .Sum  (fa_sum),
    .Cout (fa_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      msb_a_q <= 1'b0;
      msb_b_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      msb_a_q <= msb_a_d;
      msb_b_q <= msb_b_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last_nib) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Result fills from the top so the LS nibble lands at [3:0] after NIBBLES shifts.
  always_comb begin
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    msb_a_d = msb_a_q;
    msb_b_d = msb_b_q;
    if (accept) begin
      a_sh_d  = a;
      b_sh_d  = b;
      carry_d = cin;
      cnt_d   = '0;
      msb_a_d = a[WIDTH-1];
      msb_b_d = b[WIDTH-1];
    end else if (state_q == RUN) begin
      a_sh_d  = a_sh_q >> NIB_W;
      b_sh_d  = b_sh_q >> NIB_W;
      res_d   = (res_q >> NIB_W) | (WIDTH'(fa_sum) << (WIDTH - NIB_W));
      carry_d = fa_cout;
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  assign sum  = res_q;
  assign cout = carry_q;
  assign ovf  = (msb_a_q == msb_b_q) && (res_q[WIDTH-1] != msb_a_q);

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and sweep checks of nibble_serial_adder at WIDTH 16, 8 and 4
// against an a+b+cin reference model held in a scoreboard queue.
module tb_nibble_serial_adder;

  typedef struct packed {
    logic [15:0] s;
    logic        co;
    logic        ov;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        iv16 = 0, ci16 = 0, or16 = 0, ir16, ov16, co16, of16;
  logic [15:0] a16 = 0, b16 = 0, s16;
  logic        iv8 = 0, ci8 = 0, or8 = 0, ir8, ov8, co8, of8;
  logic [7:0]  a8 = 0, b8 = 0, s8;
  logic        iv4 = 0, ci4 = 0, or4 = 0, ir4, ov4, co4, of4;
  logic [3:0]  a4 = 0, b4 = 0, s4;

  int   n_assert = 0;
  int   n_fail = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .cin(ci16), .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(co16), .ovf(of16)
  );
  nibble_serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .cin(ci8), .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .ovf(of8)
  );
  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .cin(ci4), .out_valid(ov4), .out_ready(or4), .sum(s4), .cout(co4), .ovf(of4)
  );

  // Packed view of one instance: [19] in_ready, [18] out_valid, [17] cout, [16] ovf, [15:0] sum.
  function automatic logic [19:0] obs(int i);
    case (i)
      0:       return {ir16, ov16, co16, of16, s16};
      1:       return {ir8, ov8, co8, of8, 8'h00, s8};
      default: return {ir4, ov4, co4, of4, 12'h000, s4};
    endcase
  endfunction

  task automatic drive(int i, logic v, logic [15:0] a, logic [15:0] b, logic c);
    case (i)
      0:       begin iv16 = v; a16 = a; b16 = b; ci16 = c; end
      1:       begin iv8 = v; a8 = a[7:0]; b8 = b[7:0]; ci8 = c; end
      default: begin iv4 = v; a4 = a[3:0]; b4 = b[3:0]; ci4 = c; end
    endcase
  endtask

  task automatic set_ordy(int i, logic r);
    case (i)
      0:       or16 = r;
      1:       or8 = r;
      default: or4 = r;
    endcase
  endtask

  function automatic exp_t model(int w, logic [15:0] a, logic [15:0] b, logic c);
    logic [16:0] full;
    logic [15:0] mask;
    logic [15:0] am, bm;
    exp_t e;
    mask = 16'((17'd1 << w) - 17'd1);
    am = a & mask;
    bm = b & mask;
    full = {1'b0, am} + {1'b0, bm} + 17'(c);
    e.s  = full[15:0] & mask;
    e.co = full[w];
    e.ov = (am[w-1] == bm[w-1]) && (e.s[w-1] != am[w-1]);
    return e;
  endfunction

  task automatic chk(string tag, logic [31:0] observed, logic [31:0] expected);
    n_assert++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic txn(int i, logic [15:0] a, logic [15:0] b, logic c, int hold);
    int w;
    int lat;
    exp_t g;
    logic [19:0] o;
    w = 16 >> i;
    sb.push_back(model(w, a, b, c));
    drive(i, 1'b1, a, b, c);
    @(posedge clk); #1;
    drive(i, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
    lat = 0;
    o = obs(i);
    while (!o[18] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      o = obs(i);
    end
    chk("latency", lat, w / 4);
    g = sb.pop_front();
    chk("sum", {16'h0, o[15:0]}, {16'h0, g.s});
    chk("cout", {31'h0, o[17]}, {31'h0, g.co});
    chk("ovf", {31'h0, o[16]}, {31'h0, g.ov});
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk("hold_stable", {12'h0, obs(i)}, {12'h0, 1'b0, 1'b1, g.co, g.ov, g.s});
    end
    set_ordy(i, 1'b1);
    @(posedge clk); #1;
    set_ordy(i, 1'b0);
    drive(i, 1'b0, 16'h0, 16'h0, 1'b0);
    o = obs(i);
    chk("release_out_valid", {31'h0, o[18]}, 32'h0);
    chk("release_in_ready", {31'h0, o[19]}, 32'h1);
  endtask

  initial begin
    logic [19:0] o;
    #2;
    o = obs(0);
    chk("reset_state16", {12'h0, o}, {12'h0, 20'h80000});
    o = obs(1);
    chk("reset_state8", {12'h0, o}, {12'h0, 20'h80000});
    o = obs(2);
    chk("reset_state4", {12'h0, o}, {12'h0, 20'h80000});
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    txn(0, 16'h1234, 16'h4321, 1'b0, 0);
    txn(0, 16'hFFFF, 16'h0001, 1'b0, 0);
    txn(0, 16'hFFFF, 16'hFFFF, 1'b1, 0);
    txn(0, 16'h7FFF, 16'h0001, 1'b0, 0);
    txn(0, 16'h8000, 16'h8000, 1'b0, 0);
    txn(0, 16'h8000, 16'h7FFF, 1'b0, 0);
    txn(0, 16'h0000, 16'h0000, 1'b1, 0);
    txn(0, 16'hA5A5, 16'h5A5A, 1'b1, 5);
    txn(0, 16'h0F0F, 16'h00F1, 1'b0, 0);

    drive(0, 1'b1, 16'h1234, 16'h1111, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    o = obs(0);
    chk("midrun_reset_out_valid", {31'h0, o[18]}, 32'h0);
    chk("midrun_reset_in_ready", {31'h0, o[19]}, 32'h1);
    chk("midrun_reset_sum", {16'h0, o[15:0]}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    txn(0, 16'h00FF, 16'h0001, 1'b0, 0);

    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int c = 0; c < 2; c++)
          txn(2, 16'(x), 16'(y), 1'(c), 0);

    txn(1, 16'h00FF, 16'h0001, 1'b0, 0);
    txn(1, 16'h007F, 16'h0001, 1'b0, 0);
    txn(1, 16'h0080, 16'h0080, 1'b0, 0);
    txn(1, 16'h00FF, 16'h00FF, 1'b1, 2);
    for (int k = 0; k < 150; k++)
      txn(1, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)), 1'($urandom), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
